// File: rtl/prog_delay_line.sv
// prog_delay_line: variable-latency delay line; cfg changes drain in-flight beats first.
// Define PROG_DELAY_LINE_OCC_EN to add the occ (in-flight count) output.
module prog_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int RESET_DELAY = 1,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             cfg_load,
  input  logic [DW-1:0]    cfg_delay,
  output logic             cfg_busy,
`ifdef PROG_DELAY_LINE_OCC_EN
  output logic [DW-1:0]    occ,
`endif
  output logic [DW-1:0]    cur_delay
);
  typedef enum logic {RUN, DRAIN} state_t;
  state_t r_state, w_state_nxt;
  logic [DW-1:0] r_cur, r_pend, w_pend_nxt, w_clamp, w_wsel;
  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic w_acc, w_empty;
  assign w_acc = in_valid & in_ready;
  assign w_empty = ~|r_v;
  assign w_wsel = r_cur - DW'(1);
  assign w_clamp = (cfg_delay == '0) ? DW'(1) : (cfg_delay > DW'(DEPTH)) ? DW'(DEPTH) : cfg_delay;
  assign w_pend_nxt = cfg_load ? w_clamp : r_pend;
  assign in_ready = (r_state == RUN);
  assign cfg_busy = (r_state == DRAIN);
  assign out_valid = r_v[0];
  assign out_data = r_v[0] ? r_d[0] : '0;
  assign cur_delay = r_cur;
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = (r_state == RUN) ? (cfg_load ? DRAIN : RUN) : (w_empty ? RUN : DRAIN);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_cur <= DW'(RESET_DELAY);
      r_pend <= DW'(RESET_DELAY);
    end else begin
      r_state <= w_state_nxt;
      r_pend <= w_pend_nxt;
      if (r_state == DRAIN && w_empty) r_cur <= w_pend_nxt;
    end
  end
  // Slot k emits k+1 cycles after being written, so a beat enters at slot cur_delay-1.
  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic w_hit;
    assign w_hit = w_acc && (w_wsel == DW'(k));
    if (k == DEPTH - 1) begin : g_top
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_v[k] <= 1'b0;
        else r_v[k] <= w_hit;
      end
      always_ff @(posedge clk) r_d[k] <= w_hit ? in_data : '0;
    end else begin : g_mid
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_v[k] <= 1'b0;
        else r_v[k] <= w_hit | r_v[k+1];
      end
      always_ff @(posedge clk) r_d[k] <= w_hit ? in_data : r_d[k+1];
    end
  end
`ifdef PROG_DELAY_LINE_OCC_EN
  logic [DW-1:0] r_occ;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_occ <= '0;
    else r_occ <= r_occ + DW'(w_acc) - DW'(r_v[0]);
  end
  assign occ = r_occ;
`endif
endmodule

// File: tb/tb_prog_delay_line.sv
// tb_prog_delay_line: table vectors, directed corner sequences and random traffic vs a queue model.
module tb_prog_delay_line;
  localparam int WIDTH = 8, DEPTH = 16, RESET_DELAY = 1, DW = $clog2(DEPTH + 1);
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid, in_ready, out_valid, cfg_load, cfg_busy;
  logic [WIDTH-1:0] in_data, out_data;
  logic [DW-1:0] cfg_delay, cur_delay;
`ifdef PROG_DELAY_LINE_OCC_EN
  logic [DW-1:0] occ;
`endif
  always #5 clk = ~clk;
  prog_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_DELAY(RESET_DELAY)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .cfg_load(cfg_load), .cfg_delay(cfg_delay),
    .cfg_busy(cfg_busy),
`ifdef PROG_DELAY_LINE_OCC_EN
    .occ(occ),
`endif
    .cur_delay(cur_delay));
  typedef struct {logic [WIDTH-1:0] d; int due;} beat_t;
  typedef struct {bit iv; logic [7:0] id; bit ld; int cd; bit ov; logic [7:0] od; bit rdy; int cur;} vec_t;
  beat_t q[$];
  vec_t tbl[9];
  int n_chk = 0, n_fail = 0, cyc = 0, n;
  bit m_run;
  int m_cur, m_pend;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic int clampd(int v);
    return v < 1 ? 1 : v > DEPTH ? DEPTH : v;
  endfunction
  task automatic model_reset();
    q.delete();
    m_run = 1;
    m_cur = RESET_DELAY;
    m_pend = RESET_DELAY;
  endtask
  task automatic drive(bit iv, logic [7:0] id, bit ld, int cd);
    in_valid = iv;
    in_data = id;
    cfg_load = ld;
    cfg_delay = DW'(cd);
  endtask
  // Called at the negedge: compare, then advance the model to the next cycle.
  task automatic model_cycle();
    bit ev, empty;
    logic [WIDTH-1:0] ed;
    ev = q.size() > 0 && q[0].due == cyc;
    ed = ev ? q[0].d : '0;
    chk("out_valid", out_valid, ev);
    chk("out_data", out_data, ed);
    chk("in_ready", in_ready, m_run);
    chk("cfg_busy", cfg_busy, !m_run);
    chk("cur_delay", cur_delay, m_cur);
`ifdef PROG_DELAY_LINE_OCC_EN
    chk("occ", occ, q.size());
`endif
    empty = q.size() == 0;
    if (ev) void'(q.pop_front());
    if (in_valid && m_run) q.push_back('{in_data, cyc + m_cur});
    if (m_run) begin
      if (cfg_load) begin
        m_run = 0;
        m_pend = clampd(int'(cfg_delay));
      end
    end else begin
      if (cfg_load) m_pend = clampd(int'(cfg_delay));
      if (empty) begin
        m_run = 1;
        m_cur = m_pend;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic tick(bit iv, logic [7:0] id, bit ld, int cd);
    drive(iv, id, ld, cd);
    @(negedge clk);
    model_cycle();
  endtask
  task automatic wait_drain(output int cnt);
    cnt = 0;
    while (cfg_busy === 1'b1 && cnt < 40) begin
      tick(0, 0, 0, 0);
      cnt++;
    end
    chk("drain_bound", cnt < 40, 1);
  endtask
  task automatic set_delay(int d);
    int c;
    tick(0, 0, 1, d);
    wait_drain(c);
  endtask
  initial begin
    tbl = '{
      '{1, 8'hA5, 0, 0, 0, 8'h00, 1, 1},
      '{0, 8'h00, 0, 0, 1, 8'hA5, 1, 1},
      '{0, 8'h00, 0, 0, 0, 8'h00, 1, 1},
      '{0, 8'h00, 1, DEPTH + 3, 0, 8'h00, 1, 1},
      '{0, 8'h00, 0, 0, 0, 8'h00, 0, 1},
      '{0, 8'h00, 0, 0, 0, 8'h00, 1, DEPTH},
      '{0, 8'h00, 1, 0, 0, 8'h00, 1, DEPTH},
      '{0, 8'h00, 0, 0, 0, 8'h00, 0, DEPTH},
      '{0, 8'h00, 0, 0, 0, 8'h00, 1, 1}};
    drive(0, 0, 0, 0);
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cfg_busy", cfg_busy, 0);
    chk("rst_cur_delay", cur_delay, RESET_DELAY);
    rst = 0;
    repeat (10) tick(0, 0, 0, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].iv, tbl[i].id, tbl[i].ld, tbl[i].cd);
      @(negedge clk);
      chk("tbl_out_valid", out_valid, tbl[i].ov);
      chk("tbl_out_data", out_data, tbl[i].od);
      chk("tbl_in_ready", in_ready, tbl[i].rdy);
      chk("tbl_cur_delay", cur_delay, tbl[i].cur);
      model_cycle();
    end
    set_delay(5);
    for (int i = 0; i < 16; i++) tick(1, 8'(i), 0, 0);
    repeat (8) tick(0, 0, 0, 0);
    set_delay(8);
    for (int i = 0; i < 3; i++) tick(1, 8'h31 + 8'(i), 0, 0);
    tick(0, 0, 1, 2);
    wait_drain(n);
    chk("s3_drain_len", n, 8);
    chk("s3_cur_delay", cur_delay, 2);
    tick(1, 8'h44, 0, 0);
    repeat (4) tick(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(1, 8'h51 + 8'(i), 0, 0);
    tick(0, 0, 1, 3);
    tick(0, 0, 1, 7);
    wait_drain(n);
    chk("s5_drain_len", n + 1, 2);
    chk("s5_cur_delay", cur_delay, 7);
    set_delay(5);
    for (int i = 0; i < 5; i++) tick(1, 8'h61 + 8'(i), 0, 0);
    drive(0, 0, 0, 0);
    chk("s6_pre_valid", out_valid, 1);
    #2;
    rst = 1;
    #1;
    chk("s6_out_valid", out_valid, 0);
    chk("s6_out_data", out_data, 0);
    chk("s6_in_ready", in_ready, 1);
    chk("s6_cfg_busy", cfg_busy, 0);
    chk("s6_cur_delay", cur_delay, RESET_DELAY);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    repeat (12) tick(0, 0, 0, 0);
    repeat (400) tick($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 31));
    repeat (20) tick(0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
